// File: rtl/fold_adder_pipe_if.sv
// Handshake bundle for fold_adder_pipe: input operand channel and result channel.
interface fold_adder_pipe_if #(
  parameter int unsigned WIDTH = 26
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_carry;

  modport master (
    output in_valid, in_mode, op_a, op_b, out_ready,
    input  in_ready, out_valid, out, out_carry
  );

  modport slave (
    input  in_valid, in_mode, op_a, op_b, out_ready,
    output in_ready, out_valid, out, out_carry
  );
endinterface

// File: rtl/fold_adder_pipe.sv
// Parametrised fold-add pipeline: stage 0 adds the operands, later stages fold
// the halves of the previous result (unless bypassed) with a sticky carry.
module fold_adder_pipe #(
  parameter int unsigned WIDTH  = 26,
  parameter int unsigned STAGES = 6
) (
  input logic               clock0,
  input logic               reset,
  fold_adder_pipe_if.slave  io
);
  localparam int unsigned H = WIDTH / 2;

  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0]            m_q, m_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] d_q, d_d;
  logic                         advance;
  logic [WIDTH:0]               sum0;
  logic [WIDTH:0]               fold_sum;

  always_comb begin
    advance  = !v_q[STAGES-1] | io.out_ready;
    v_d      = v_q;
    m_d      = m_q;
    c_d      = c_q;
    d_d      = d_q;
    sum0     = {1'b0, io.op_a} + {1'b0, io.op_b};
    fold_sum = '0;
    if (advance) begin
      v_d[0] = io.in_valid;
      m_d[0] = io.in_mode;
      d_d[0] = sum0[WIDTH-1:0];
      c_d[0] = sum0[WIDTH];
      for (int unsigned k = 1; k < STAGES; k++) begin
        v_d[k] = v_q[k-1];
        m_d[k] = m_q[k-1];
        if (m_q[k-1]) begin
          d_d[k] = d_q[k-1];
          c_d[k] = c_q[k-1];
        end else begin
          // {lo,lo} + {hi,hi}: each half replicated to full width before adding
          fold_sum = {1'b0, d_q[k-1][H-1:0], d_q[k-1][H-1:0]}
                   + {1'b0, d_q[k-1][WIDTH-1:H], d_q[k-1][WIDTH-1:H]};
          d_d[k]   = fold_sum[WIDTH-1:0];
          c_d[k]   = c_q[k-1] | fold_sum[WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      m_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      m_q <= m_d;
      c_q <= c_d;
      d_q <= d_d;
    end
  end

  assign io.in_ready  = advance;
  assign io.out_valid = v_q[STAGES-1];
  assign io.out       = d_q[STAGES-1];
  assign io.out_carry = c_q[STAGES-1];
endmodule

// File: tb/tb_fold_adder_pipe.sv
// Self-checking bench for fold_adder_pipe: default 26/6 instance plus
// WIDTH=8 instances with STAGES=1 and STAGES=3 checked against a transaction model.
module tb_fold_adder_pipe;
  logic clock0 = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] res;
    bit          cy;
  } exp_t;

  fold_adder_pipe_if #(.WIDTH(26)) bus  ();
  fold_adder_pipe_if #(.WIDTH(8))  bus1 ();
  fold_adder_pipe_if #(.WIDTH(8))  bus3 ();

  fold_adder_pipe #(.WIDTH(26), .STAGES(6)) dut  (.clock0(clock0), .reset(reset), .io(bus));
  fold_adder_pipe #(.WIDTH(8),  .STAGES(1)) dut1 (.clock0(clock0), .reset(reset), .io(bus1));
  fold_adder_pipe #(.WIDTH(8),  .STAGES(3)) dut3 (.clock0(clock0), .reset(reset), .io(bus3));

  always #5 clock0 = ~clock0;

  // Transaction-level reference: add, then fold (stages-1) times unless bypassed.
  function automatic exp_t model(input int unsigned w, input int unsigned stages,
                                 input longint unsigned a, input longint unsigned b,
                                 input bit mode);
    longint unsigned mask, hmask, s, d, lo, hi;
    int unsigned h;
    exp_t e;
    h     = w / 2;
    mask  = (64'd1 << w) - 1;
    hmask = (64'd1 << h) - 1;
    s     = (a & mask) + (b & mask);
    e.cy  = s[w];
    d     = s & mask;
    if (!mode) begin
      for (int unsigned k = 1; k < stages; k++) begin
        lo   = d & hmask;
        hi   = d >> h;
        s    = ((lo << h) | lo) + ((hi << h) | hi);
        e.cy = e.cy | s[w];
        d    = s & mask;
      end
    end
    e.res = d[31:0];
    return e;
  endfunction

  task automatic step();
    @(posedge clock0);
    #1;
  endtask

  task automatic issue(input logic [25:0] a, input logic [25:0] b, input bit mode);
    bus.op_a = a; bus.op_b = b; bus.in_mode = mode; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op_a = 26'd123; bus.op_b = 26'd77; bus.in_mode = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_prefill out_valid got %b want 1", bus.out_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out !== 26'd0) begin
      errors++; $display("FAIL reset_out got %0d want 0", bus.out);
    end
    checks++;
    if (bus.out_carry !== 1'b0) begin
      errors++; $display("FAIL reset_out_carry got %b want 0", bus.out_carry);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    step();
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (bus.out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++; $display("FAIL reset_no_partial out_valid seen %b want 0", seen);
      end
    end
  endtask

  task automatic test_fold_defaults();
    bus.out_ready = 1'b1;
    issue(26'd5, 26'd3, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (bus.out_valid !== (i == 5)) begin
        errors++; $display("FAIL fold_latency edge+%0d out_valid got %b want %b", i, bus.out_valid, i == 5);
      end
    end
    checks++;
    if (bus.out !== 26'd1048704) begin
      errors++; $display("FAIL fold_default_out got %0d want 1048704", bus.out);
    end
    checks++;
    if (bus.out_carry !== 1'b0) begin
      errors++; $display("FAIL fold_default_carry got %b want 0", bus.out_carry);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL fold_default_drain out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_single(input string name, input logic [25:0] a, input logic [25:0] b,
                             input bit mode, input bit want_cy);
    exp_t e;
    int   n = 0;
    e = model(26, 6, a, b, mode);
    bus.out_ready = 1'b1;
    issue(a, b, mode);
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout out_valid got %b want 1", name, bus.out_valid);
    end
    checks++;
    if (bus.out !== e.res[25:0]) begin
      errors++; $display("FAIL %s_out got 0x%0h want 0x%0h", name, bus.out, e.res[25:0]);
    end
    checks++;
    if (bus.out_carry !== want_cy) begin
      errors++; $display("FAIL %s_carry got %b want %b", name, bus.out_carry, want_cy);
    end
    step();
  endtask

  task automatic test_back_to_back();
    exp_t        q[$];
    exp_t        e;
    int          sent = 0, got = 0, cyc = 0;
    bit          pending = 1'b0, acc, xfer, prev_stall = 1'b0;
    logic [25:0] prev_out = '0;
    bit          prev_cy = 1'b0;
    while (got < 10 && cyc < 200) begin
      bus.out_ready = !(cyc >= 7 && cyc <= 10);
      if (!pending && sent < 10) begin
        bus.op_a    = 26'($urandom);
        bus.op_b    = 26'($urandom);
        bus.in_mode = sent[0];
        pending     = 1'b1;
      end
      bus.in_valid = pending;
      #1;
      acc  = bus.in_valid && bus.in_ready;
      xfer = bus.out_valid && bus.out_ready;
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready cyc %0d got %b want 0", cyc, bus.in_ready);
        end
        if (prev_stall) begin
          checks++;
          if (bus.out !== prev_out || bus.out_carry !== prev_cy) begin
            errors++; $display("FAIL stall_hold cyc %0d got 0x%0h/%b want 0x%0h/%b",
                               cyc, bus.out, bus.out_carry, prev_out, prev_cy);
          end
        end
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      prev_out = bus.out;
      prev_cy  = bus.out_carry;
      if (acc) begin
        q.push_back(model(26, 6, bus.op_a, bus.op_b, bus.in_mode));
        sent++;
        pending = 1'b0;
      end
      if (xfer) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got 0x%0h want no output", bus.out);
        end else begin
          e = q.pop_front();
          if (bus.out !== e.res[25:0] || bus.out_carry !== e.cy) begin
            errors++; $display("FAIL b2b_result #%0d got 0x%0h/%b want 0x%0h/%b",
                               got, bus.out, bus.out_carry, e.res[25:0], e.cy);
          end
        end
        got++;
      end
      @(posedge clock0);
      #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got != 10 || q.size() != 0) begin
      errors++; $display("FAIL b2b_count delivered %0d pending %0d want 10/0", got, q.size());
    end
  endtask

  task automatic test_param_sweep();
    exp_t q1[$], q3[$];
    exp_t e;
    bit   p1 = 1'b0, p3 = 1'b0;
    int   n1 = 0, n3 = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit drive = (cyc < 300);
      if (!p1 && drive && ($urandom % 4 != 0)) begin
        bus1.op_a = 8'($urandom); bus1.op_b = 8'($urandom); bus1.in_mode = 1'($urandom);
        p1 = 1'b1;
      end
      if (!p3 && drive && ($urandom % 4 != 0)) begin
        bus3.op_a = 8'($urandom); bus3.op_b = 8'($urandom); bus3.in_mode = 1'($urandom);
        p3 = 1'b1;
      end
      bus1.in_valid  = p1;
      bus3.in_valid  = p3;
      bus1.out_ready = drive ? ($urandom % 3 != 0) : 1'b1;
      bus3.out_ready = drive ? ($urandom % 3 != 0) : 1'b1;
      #1;
      if (bus1.out_valid && bus1.out_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL sweep_s1_extra got 0x%0h want no output", bus1.out);
        end else begin
          e = q1.pop_front();
          if (bus1.out !== e.res[7:0] || bus1.out_carry !== e.cy) begin
            errors++; $display("FAIL sweep_s1 #%0d got 0x%0h/%b want 0x%0h/%b",
                               n1, bus1.out, bus1.out_carry, e.res[7:0], e.cy);
          end
        end
        n1++;
      end
      if (bus3.out_valid && bus3.out_ready) begin
        checks++;
        if (q3.size() == 0) begin
          errors++; $display("FAIL sweep_s3_extra got 0x%0h want no output", bus3.out);
        end else begin
          e = q3.pop_front();
          if (bus3.out !== e.res[7:0] || bus3.out_carry !== e.cy) begin
            errors++; $display("FAIL sweep_s3 #%0d got 0x%0h/%b want 0x%0h/%b",
                               n3, bus3.out, bus3.out_carry, e.res[7:0], e.cy);
          end
        end
        n3++;
      end
      if (bus1.in_valid && bus1.in_ready) begin
        q1.push_back(model(8, 1, bus1.op_a, bus1.op_b, bus1.in_mode));
        p1 = 1'b0;
      end
      if (bus3.in_valid && bus3.in_ready) begin
        q3.push_back(model(8, 3, bus3.op_a, bus3.op_b, bus3.in_mode));
        p3 = 1'b0;
      end
      @(posedge clock0);
      #1;
    end
    bus1.in_valid = 1'b0;
    bus3.in_valid = 1'b0;
    checks++;
    if (q1.size() != 0 || n1 == 0) begin
      errors++; $display("FAIL sweep_s1_drain pending %0d delivered %0d want 0/>0", q1.size(), n1);
    end
    checks++;
    if (q3.size() != 0 || n3 == 0) begin
      errors++; $display("FAIL sweep_s3_drain pending %0d delivered %0d want 0/>0", q3.size(), n3);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0; bus.in_mode  = 1'b0; bus.op_a  = '0; bus.op_b  = '0; bus.out_ready  = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_mode = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.out_ready = 1'b1;
    bus3.in_valid = 1'b0; bus3.in_mode = 1'b0; bus3.op_a = '0; bus3.op_b = '0; bus3.out_ready = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    test_reset();
    test_fold_defaults();
    test_single("bypass_ovf", 26'h3FFFFFF, 26'd1, 1'b1, 1'b1);
    test_single("fold_carry", 26'h3FFFFFF, 26'd0, 1'b0, 1'b1);
    test_back_to_back();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
